// File: rtl/warp_dispatch_tracker_if.sv
// Issue/writeback bundle between the warp scheduler (master) and the dispatch tracker (slave).
interface warp_dispatch_tracker_if #(
    parameter int WARPS = 8,
    parameter int IDW   = 3,
    parameter int CW    = 4
);
    logic [WARPS-1:0] warp_enable;
    logic             issue_valid;
    logic [WARPS-1:0] issue_onehot;
    logic             issue_accept;
    logic             exec_stall;
    logic [WARPS-1:0] ready_mask;
    logic             wb_valid;
    logic [IDW-1:0]   wb_warp_id;
    logic [CW-1:0]    inflight;
    logic             err;
    logic             err_clear;

    modport master (
        output warp_enable, issue_valid, issue_onehot, exec_stall, err_clear,
        input  issue_accept, ready_mask, wb_valid, wb_warp_id, inflight, err
    );

    modport slave (
        input  warp_enable, issue_valid, issue_onehot, exec_stall, err_clear,
        output issue_accept, ready_mask, wb_valid, wb_warp_id, inflight, err
    );
endinterface

// File: rtl/warp_dispatch_tracker.sv
// Accepts one-hot warp issues, carries them through a LAT-deep execute pipeline and
// keeps each warp busy until its writeback, feeding ready_mask back to the scheduler.
module warp_dispatch_tracker #(
    parameter int WARPS = 8,
    parameter int IDW   = 3,
    parameter int LAT   = 4,
    parameter int CW    = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    warp_dispatch_tracker_if.slave bus
);

    logic [WARPS-1:0] busy;
    logic [LAT-1:0]   vld_p;
    logic [IDW-1:0]   id_p [LAT];
    logic [CW-1:0]    count;
    logic             err_q;

    logic [IDW-1:0]   issue_id;
    logic             legal;
    logic             accept;
    logic             wb;
    logic [WARPS-1:0] set_mask;
    logic [WARPS-1:0] clr_mask;

    function automatic logic [IDW-1:0] encode(input logic [WARPS-1:0] oh);
        logic [IDW-1:0] idx;
        idx = '0;
        for (int i = 0; i < WARPS; i++) begin
            if (oh[i]) idx = idx | IDW'(i);
        end
        return idx;
    endfunction

    function automatic logic exactly_one(input logic [WARPS-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < WARPS; i++) begin
            if (v[i]) n = n + 1;
        end
        return (n == 1);
    endfunction

    // Legality looks only at the issue bundle and local flops, never at ready_mask.
    always_comb begin
        issue_id = encode(bus.issue_onehot);
        legal    = exactly_one(bus.issue_onehot)
                   && (|(bus.issue_onehot & bus.warp_enable & ~busy));
        accept   = bus.issue_valid && legal && !bus.exec_stall && !rst;
        wb       = vld_p[LAT-1] && !bus.exec_stall;
        set_mask = accept ? bus.issue_onehot : '0;
        clr_mask = wb ? ({{(WARPS-1){1'b0}}, 1'b1} << id_p[LAT-1]) : '0;
    end

    assign bus.issue_accept = accept;
    assign bus.wb_valid     = wb;
    assign bus.wb_warp_id   = wb ? id_p[LAT-1] : '0;
    assign bus.ready_mask   = bus.warp_enable & ~busy;
    assign bus.inflight     = count;
    assign bus.err          = err_q;

    // Control state: busy set, stage valids, in-flight count, sticky error
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy  <= '0;
            vld_p <= '0;
            count <= '0;
            err_q <= 1'b0;
        end else begin
            if (bus.issue_valid && !legal) begin
                err_q <= 1'b1;
            end else if (bus.err_clear) begin
                err_q <= 1'b0;
            end
            if (!bus.exec_stall) begin
                busy     <= (busy | set_mask) & ~clr_mask;
                vld_p[0] <= accept;
                for (int i = 1; i < LAT; i++) begin
                    vld_p[i] <= vld_p[i-1];
                end
                count <= count + CW'(accept) - CW'(wb);
            end
        end
    end

    // Stage ids are qualified by vld_p, so they carry no reset
    always_ff @(posedge clk) begin
        if (!bus.exec_stall) begin
            id_p[0] <= issue_id;
            for (int i = 1; i < LAT; i++) begin
                id_p[i] <= id_p[i-1];
            end
        end
    end

endmodule

// File: tb/tb_warp_dispatch_tracker.sv
// Bench for warp_dispatch_tracker: directed test-plan scenarios plus randomized traffic,
// each cycle checked against an age-queue reference model.
module tb_warp_dispatch_tracker;

    localparam int WARPS = 8;
    localparam int IDW   = 3;
    localparam int LAT   = 4;
    localparam int CW    = 4;

    typedef struct {
        int id;
        int age;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    warp_dispatch_tracker_if #(.WARPS(WARPS), .IDW(IDW), .CW(CW)) bus ();

    warp_dispatch_tracker #(.WARPS(WARPS), .IDW(IDW), .LAT(LAT), .CW(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int         tests = 0;
    int         fails = 0;
    ent_t       q[$];
    logic [7:0] mbusy = '0;
    logic       merr  = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_legal(input logic [7:0] oh, input logic [7:0] en);
        return ($countones(oh) == 1) && ((oh & en & ~mbusy) != 0);
    endfunction

    function automatic int oh_index(input logic [7:0] oh);
        for (int i = 0; i < WARPS; i++) if (oh[i]) return i;
        return 0;
    endfunction

    task automatic model_clear();
        q.delete();
        mbusy = '0;
        merr  = 1'b0;
    endtask

    // One clock cycle: drive, check combinational/flop outputs at negedge, advance model at posedge.
    task automatic cyc(input logic iv, input logic [7:0] oh, input logic st,
                       input logic ec, input logic [7:0] en);
        bit lg, acc, wbv;
        int wid;
        bus.issue_valid  = iv;
        bus.issue_onehot = oh;
        bus.exec_stall   = st;
        bus.err_clear    = ec;
        bus.warp_enable  = en;
        @(negedge clk);
        lg  = m_legal(oh, en);
        acc = iv && lg && !st;
        wbv = (q.size() > 0) && (q[0].age == LAT) && !st;
        wid = wbv ? q[0].id : 0;
        check("issue_accept", 32'(bus.issue_accept), 32'(acc));
        check("wb_valid",     32'(bus.wb_valid),     32'(wbv));
        check("wb_warp_id",   32'(bus.wb_warp_id),   32'(wid));
        check("ready_mask",   32'(bus.ready_mask),   32'(en & ~mbusy));
        check("inflight",     32'(bus.inflight),     32'(q.size()));
        check("err",          32'(bus.err),          32'(merr));
        @(posedge clk);
        if (iv && !lg) merr = 1'b1;
        else if (ec) merr = 1'b0;
        if (!st) begin
            if (wbv) begin
                mbusy[q[0].id] = 1'b0;
                void'(q.pop_front());
            end
            foreach (q[i]) q[i].age++;
            if (acc) begin
                q.push_back('{id: oh_index(oh), age: 1});
                mbusy = mbusy | oh;
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b0, 1'b0, 8'hFF);
    endtask

    task automatic do_reset();
        rst              = 1'b1;
        bus.issue_valid  = 1'b1;
        bus.issue_onehot = 8'h01;
        bus.exec_stall   = 1'b0;
        bus.err_clear    = 1'b0;
        bus.warp_enable  = 8'hFF;
        repeat (2) @(posedge clk);
        #1;
        check("rst_accept",   32'(bus.issue_accept), 32'd0);
        check("rst_wb_valid", 32'(bus.wb_valid),     32'd0);
        check("rst_wb_id",    32'(bus.wb_warp_id),   32'd0);
        check("rst_inflight", 32'(bus.inflight),     32'd0);
        check("rst_err",      32'(bus.err),          32'd0);
        check("rst_ready",    32'(bus.ready_mask),   32'hFF);
        rst             = 1'b0;
        bus.issue_valid = 1'b0;
        model_clear();
    endtask

    initial begin
        logic [7:0] en_r;
        logic [7:0] oh_r;

        // Single issue of warp 2
        do_reset();
        cyc(1'b1, 8'h04, 1'b0, 1'b0, 8'hFF);
        check("p1_ready_c2", 32'(bus.ready_mask), 32'hFB);
        check("p1_infl_c2",  32'(bus.inflight),   32'd1);
        idle(3);
        check("p1_wb_c5",    32'(bus.wb_valid),   32'd1);
        check("p1_wbid_c5",  32'(bus.wb_warp_id), 32'd2);
        idle(1);
        check("p1_ready_c6", 32'(bus.ready_mask), 32'hFF);
        check("p1_infl_c6",  32'(bus.inflight),   32'd0);

        // Back-to-back accepts of warps 0..3, fifth accept overlaps first writeback
        do_reset();
        for (int w = 0; w < 4; w++) cyc(1'b1, 8'(1 << w), 1'b0, 1'b0, 8'hFF);
        check("p2_infl_peak", 32'(bus.inflight),   32'd4);
        check("p2_wbid0",     32'(bus.wb_warp_id), 32'd0);
        cyc(1'b1, 8'h10, 1'b0, 1'b0, 8'hFF);
        check("p2_infl_net0", 32'(bus.inflight),   32'd4);
        check("p2_wbid1",     32'(bus.wb_warp_id), 32'd1);
        idle(8);

        // Stall during flight of warp 5
        do_reset();
        cyc(1'b1, 8'h20, 1'b0, 1'b0, 8'hFF);
        idle(1);
        cyc(1'b1, 8'h01, 1'b1, 1'b0, 8'hFF);
        cyc(1'b1, 8'h01, 1'b1, 1'b0, 8'hFF);
        idle(1);
        check("p3_no_wb_c6", 32'(bus.wb_valid), 32'd0);
        idle(1);
        check("p3_wb_c7",    32'(bus.wb_valid),   32'd1);
        check("p3_wbid_c7",  32'(bus.wb_warp_id), 32'd5);
        check("p3_err",      32'(bus.err),        32'd0);
        idle(2);

        // Illegal issues and err clear
        do_reset();
        cyc(1'b1, 8'h06, 1'b0, 1'b0, 8'hFF);
        check("p4_err_multi", 32'(bus.err), 32'd1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 8'hFF);
        check("p4_err_clr",   32'(bus.err), 32'd0);
        cyc(1'b1, 8'h00, 1'b0, 1'b0, 8'hFF);
        check("p4_err_zero",  32'(bus.err), 32'd1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 8'hFF);
        cyc(1'b1, 8'h02, 1'b0, 1'b0, 8'hFF);
        cyc(1'b1, 8'h02, 1'b0, 1'b0, 8'hFF);
        check("p4_err_busy",  32'(bus.err),      32'd1);
        check("p4_infl_busy", 32'(bus.inflight), 32'd1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 8'hFF);
        cyc(1'b1, 8'h10, 1'b0, 1'b0, 8'hEF);
        check("p4_err_dis",   32'(bus.err), 32'd1);
        cyc(1'b1, 8'h06, 1'b0, 1'b1, 8'hFF);
        check("p4_set_wins",  32'(bus.err), 32'd1);
        idle(6);

        // Warp 3 in flight, enable dropped, then asynchronous reset mid-flight
        do_reset();
        cyc(1'b1, 8'h08, 1'b0, 1'b0, 8'hFF);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 8'hF7);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 8'hF7);
        bus.issue_valid  = 1'b1;
        bus.issue_onehot = 8'h01;
        #1 rst = 1'b1;
        #1;
        check("p5_rst_accept", 32'(bus.issue_accept), 32'd0);
        check("p5_rst_wb",     32'(bus.wb_valid),     32'd0);
        check("p5_rst_infl",   32'(bus.inflight),     32'd0);
        check("p5_rst_ready",  32'(bus.ready_mask),   32'hF7);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("p5_no_wb3", 32'(bus.wb_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.issue_valid = 1'b0;
        model_clear();
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 8'hFF);
        check("p5_ready_ff", 32'(bus.ready_mask), 32'hFF);

        // Randomized traffic
        do_reset();
        en_r = 8'hFF;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 15) == 0) en_r[$urandom_range(0, 7)] ^= 1'b1;
            if ($urandom_range(0, 7) != 0) oh_r = 8'(1 << $urandom_range(0, 7));
            else oh_r = 8'($urandom());
            cyc(1'($urandom_range(0, 3) != 0), oh_r, 1'($urandom_range(0, 4) == 0),
                1'($urandom_range(0, 7) == 0), en_r);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
